// File: rtl/act_vec_packer.sv
// ---------------------------------------------------------------------------
// act_vec_packer
//
// Packs a stream of FP activation results (one element per handshake) into
// VLEN-element vectors for the sparse-aware stages downstream. Each vector
// is delivered together with a zero mask (zero or padded slots) and two
// counts: non-zero real elements and real (non-padded) elements.
//
// Datapath: a gather buffer collects elements; a completed vector moves to
// an AXI-style output register. When the output register is still occupied
// by an undrained vector, the completed gather buffer is held (HOLD) and
// input is stalled until the consumer takes the output vector.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data / in_last valid
//   in_ready   : block accepts an element this cycle
//   in_data    : activation result (sign|exp|mantissa)
//   in_last    : element closes the current vector early
//   out_valid  : out_* hold a complete vector
//   out_ready  : consumer accepts the vector
//   out_data   : slot k at bits [k*I_DATA +: I_DATA]
//   out_zmask  : bit k = 1 if slot k is zero or padding
//   out_nnz    : count of non-zero real elements
//   out_len    : count of real elements, 1..VLEN
// ---------------------------------------------------------------------------
module act_vec_packer #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int VLEN   = 8,
  parameter int CNT_W  = $clog2(VLEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [I_DATA-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VLEN*I_DATA-1:0]   out_data,
  output logic [VLEN-1:0]          out_zmask,
  output logic [CNT_W-1:0]         out_nnz,
  output logic [CNT_W-1:0]         out_len
);

  localparam int                 IDX_W    = $clog2(VLEN);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(VLEN - 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  // Zero test ignores the sign bit, so +0 and -0 are both zero.
  // NaN, Inf and denormals all have a non-zero exp|mantissa field.
  function automatic logic is_zero_f(input logic [I_DATA-1:0] d);
    return (d[I_DATA-2:0] == {(I_DATA-1){1'b0}});
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [VLEN*I_DATA-1:0]   gbuf_q, gbuf_d;     // gather buffer data
  logic [VLEN-1:0]          gzm_q, gzm_d;       // gather buffer zero mask
  logic [CNT_W-1:0]         gnnz_q, gnnz_d;     // non-zero accumulator
  logic [CNT_W-1:0]         glen_q, glen_d;     // length accumulator

  logic                     ovalid_q, ovalid_d;
  logic [VLEN*I_DATA-1:0]   odata_q, odata_d;
  logic [VLEN-1:0]          ozm_q, ozm_d;
  logic [CNT_W-1:0]         onnz_q, onnz_d;
  logic [CNT_W-1:0]         olen_q, olen_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                     acc_s;        // element handshake this cycle
  logic                     is_zero_s;
  logic                     complete_s;   // accepted element closes a vector
  logic                     out_free_s;   // output register can take a vector
  logic [VLEN*I_DATA-1:0]   wr_data_s;    // gather buffer incl. this element
  logic [VLEN-1:0]          wr_zm_s;
  logic [CNT_W-1:0]         wr_nnz_s;
  logic [CNT_W-1:0]         wr_len_s;

  // in_ready is a function of registered state only (plus reset), never of
  // out_ready, so no combinational path exists from the consumer back to
  // the producer.
  assign in_ready   = rst_n && (state_q == S_FILL);

  assign acc_s      = in_valid && in_ready;
  assign is_zero_s  = is_zero_f(in_data);
  assign complete_s = acc_s && (in_last || (idx_q == LAST_IDX));
  assign out_free_s = !ovalid_q || out_ready;

  // Gather buffer contents as they would look with the current element
  // written; lets a completing element go straight into the output register.
  always_comb begin
    wr_data_s = gbuf_q;
    wr_zm_s   = gzm_q;
    wr_nnz_s  = gnnz_q;
    wr_len_s  = glen_q;
    if (acc_s) begin
      wr_data_s[int'(idx_q)*I_DATA +: I_DATA] = in_data;
      wr_zm_s[idx_q]                         = is_zero_s;
      wr_len_s                               = glen_q + CNT_W'(1);
      if (!is_zero_s) begin
        wr_nnz_s = gnnz_q + CNT_W'(1);
      end else begin
        wr_nnz_s = gnnz_q;
      end
    end else begin
      wr_len_s = glen_q;
    end
  end

  // Next-state logic for the FILL/HOLD controller, gather buffer and
  // output register.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gbuf_d   = gbuf_q;
    gzm_d    = gzm_q;
    gnnz_d   = gnnz_q;
    glen_d   = glen_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    ozm_d    = ozm_q;
    onnz_d   = onnz_q;
    olen_d   = olen_q;

    case (state_q)
      S_FILL: begin
        gbuf_d = wr_data_s;
        gzm_d  = wr_zm_s;
        gnnz_d = wr_nnz_s;
        glen_d = wr_len_s;
        if (acc_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end

        if (complete_s) begin
          if (out_free_s) begin
            // Completed vector bypasses HOLD straight into the output.
            ovalid_d = 1'b1;
            odata_d  = wr_data_s;
            ozm_d    = wr_zm_s;
            onnz_d   = wr_nnz_s;
            olen_d   = wr_len_s;
            // Cleared slots double as padding: data 0, zmask 1.
            idx_d    = {IDX_W{1'b0}};
            gbuf_d   = {(VLEN*I_DATA){1'b0}};
            gzm_d    = {VLEN{1'b1}};
            gnnz_d   = {CNT_W{1'b0}};
            glen_d   = {CNT_W{1'b0}};
          end else begin
            // Output still occupied: park the full vector in the buffer.
            state_d = S_HOLD;
          end
        end else if (ovalid_q && out_ready) begin
          ovalid_d = 1'b0;
        end else begin
          ovalid_d = ovalid_q;
        end
      end

      S_HOLD: begin
        // out_valid is necessarily set here; a handshake swaps the held
        // vector in, so out_valid stays asserted.
        if (out_ready) begin
          ovalid_d = 1'b1;
          odata_d  = gbuf_q;
          ozm_d    = gzm_q;
          onnz_d   = gnnz_q;
          olen_d   = glen_q;
          idx_d    = {IDX_W{1'b0}};
          gbuf_d   = {(VLEN*I_DATA){1'b0}};
          gzm_d    = {VLEN{1'b1}};
          gnnz_d   = {CNT_W{1'b0}};
          glen_d   = {CNT_W{1'b0}};
          state_d  = S_FILL;
        end else begin
          state_d  = S_HOLD;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      idx_q    <= {IDX_W{1'b0}};
      gbuf_q   <= {(VLEN*I_DATA){1'b0}};
      gzm_q    <= {VLEN{1'b1}};
      gnnz_q   <= {CNT_W{1'b0}};
      glen_q   <= {CNT_W{1'b0}};
      ovalid_q <= 1'b0;
      odata_q  <= {(VLEN*I_DATA){1'b0}};
      ozm_q    <= {VLEN{1'b0}};
      onnz_q   <= {CNT_W{1'b0}};
      olen_q   <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gbuf_q   <= gbuf_d;
      gzm_q    <= gzm_d;
      gnnz_q   <= gnnz_d;
      glen_q   <= glen_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      ozm_q    <= ozm_d;
      onnz_q   <= onnz_d;
      olen_q   <= olen_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_zmask = ozm_q;
  assign out_nnz   = onnz_q;
  assign out_len   = olen_q;

endmodule

// File: tb/tb_act_vec_packer.sv
module tb_act_vec_packer;

  localparam int W  = 32;
  localparam int VL = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [VL*W-1:0]   out_data;
  logic [VL-1:0]     out_zmask;
  logic [CW-1:0]     out_nnz;
  logic [CW-1:0]     out_len;

  act_vec_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zmask (out_zmask),
    .out_nnz   (out_nnz),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [VL*W-1:0] data;
    logic [VL-1:0]   zm;
    logic [CW-1:0]   nnz;
    logic [CW-1:0]   len;
  } exp_t;

  typedef struct {
    logic [VL*W-1:0] el;
    int              n;
    logic            lst;
    logic [VL-1:0]   zm;
    int              nnz;
    int              len;
  } vec_t;

  exp_t exp_q[$];
  int   ocyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VL*W-1:0] act, input logic [VL*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected vector from a list of n real elements: pad with 0 / zmask 1.
  function automatic exp_t model(input logic [VL*W-1:0] el, input int n);
    exp_t e;
    e.data = '0;
    e.zm   = '1;
    e.nnz  = '0;
    e.len  = CW'(n);
    for (int k = 0; k < VL; k++) begin
      if (k < n) begin
        e.data[k*W +: W] = el[k*W +: W];
        e.zm[k] = (el[k*W +: W-1] == '0);
        if (!e.zm[k]) e.nnz = e.nnz + 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [VL*W-1:0] pk(input logic [W-1:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [VL*W-1:0] rnd_vec();
    logic [VL*W-1:0] v;
    for (int k = 0; k < VL; k++) begin
      v[k*W +: W] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    end
    return v;
  endfunction

  // Output scoreboard: compare every delivered vector with the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      ocyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_zmask", VL*W'(out_zmask), VL*W'(e.zm));
        check("out_nnz", VL*W'(out_nnz), VL*W'(e.nnz));
        check("out_len", VL*W'(out_len), VL*W'(e.len));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake.
  task automatic send(input logic [W-1:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [VL*W-1:0] el, input int n, input logic lst);
    for (int k = 0; k < n; k++) send(el[k*W +: W], lst && (k == n - 1));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain", VL*W'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, VL*W'(out_valid), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_zmask"}, VL*W'(out_zmask), '0);
    check({tag, "_out_nnz"}, VL*W'(out_nnz), '0);
    check({tag, "_out_len"}, VL*W'(out_len), '0);
    check({tag, "_in_ready"}, VL*W'(in_ready), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl[7];
    exp_t            e, e1, e2, e3;
    logic [VL*W-1:0] v, v1, v2;
    int              t0, t1;

    // Hand-derived vectors: zmask/nnz/len are independent expectations.
    tbl[0] = '{pk(32'h3F800000, 32'h0, 32'h80000000, 32'h40000000, 32'h0, 32'h0, 32'h40400000, 32'h7FC00000), 8, 1'b0, 8'h36, 4, 8};
    tbl[1] = '{pk(32'h3F800000, 32'h0, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 3, 1'b1, 8'hFA, 2, 3};
    tbl[2] = '{pk(32'h40A00000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1, 1'b1, 8'hFE, 1, 1};
    tbl[3] = '{pk(32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1, 1'b1, 8'hFF, 0, 1};
    tbl[4] = '{pk(32'h00000001, 32'h7F800000, 32'hFF800000, 32'h80000001, 32'h0, 32'h80000000, 32'h0, 32'h00400000), 8, 1'b0, 8'h70, 5, 8};
    tbl[5] = '{pk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000), 8, 1'b1, 8'h00, 8, 8};
    tbl[6] = '{pk(32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 5, 1'b1, 8'hFF, 0, 5};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", VL*W'(in_ready), VL*W'(1));
    check("release_out_valid", VL*W'(out_valid), '0);
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      e     = model(tbl[i].el, tbl[i].n);
      e.zm  = tbl[i].zm;
      e.nnz = CW'(tbl[i].nnz);
      e.len = CW'(tbl[i].len);
      exp_q.push_back(e);
      send_vec(tbl[i].el, tbl[i].n, tbl[i].lst);
    end
    wait_drain();

    // Latency: out_valid only in the cycle after the completing handshake
    v = rnd_vec();
    exp_q.push_back(model(v, 8));
    send_vec(v, 7, 1'b0);
    @(negedge clk);
    check("latency_pre", VL*W'(out_valid), '0);
    @(posedge clk);
    #1;
    send(v[7*W +: W], 1'b0);
    @(negedge clk);
    check("latency_post", VL*W'(out_valid), VL*W'(1));
    @(posedge clk);
    #1;
    wait_drain();

    // Continuous stream of 4 vectors, no in_ready bubble
    ocyc_q.delete();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      v = rnd_vec();
      exp_q.push_back(model(v, 8));
      send_vec(v, 8, 1'b0);
    end
    t1 = cyc;
    check("stream_cycles", VL*W'(t1 - t0), VL*W'(32));
    wait_drain();
    check("stream_vectors", VL*W'(ocyc_q.size()), VL*W'(4));
    for (int i = 1; i < ocyc_q.size(); i++) begin
      check("stream_spacing", VL*W'(ocyc_q[i] - ocyc_q[i-1]), VL*W'(8));
    end

    // Backpressure through two full vectors
    v1 = rnd_vec();
    v2 = rnd_vec();
    e1 = model(v1, 8);
    e2 = model(v2, 8);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    out_ready = 1'b0;
    send_vec(v1, 8, 1'b0);
    send_vec(v2, 8, 1'b0);
    @(negedge clk);
    check("hold_in_ready", VL*W'(in_ready), '0);
    check("hold_out_valid", VL*W'(out_valid), VL*W'(1));
    check("hold_out_data", out_data, e1.data);
    v = '0;
    v[W-1:0] = 32'h41000000;
    e3 = model(v, 1);
    exp_q.push_back(e3);
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_blocked", VL*W'(in_ready), '0);
      check("hold_stable", out_data, e1.data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_cycle_in_ready", VL*W'(in_ready), '0);
    @(negedge clk);
    check("hold_exit_in_ready", VL*W'(in_ready), VL*W'(1));
    check("hold_exit_data", out_data, e2.data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();

    // Reset mid-vector with an undrained output vector
    out_ready = 1'b0;
    send_vec(rnd_vec(), 8, 1'b0);
    send_vec(rnd_vec(), 5, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_reset_no_output", VL*W'(out_valid), '0);
    @(posedge clk);
    #1;
    v = rnd_vec();
    exp_q.push_back(model(v, 8));
    send_vec(v, 8, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
